ysyx_ifq: RTL and testbench
===========================

# ysyx_ifq

Instruction fetch queue between the I-cache port and the decode stage. Sequences fetch PCs, issues one outstanding fetch request at a time, and buffers returned instructions with their PC and predicted next PC (static pc+4) in a small FIFO. Presents the FIFO head to decode through a valid/ready handshake. A backend redirect flushes the queue and drops any in-flight response.

## Interface
- XLEN, 32: PC/address width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h8000_0000: first fetch address after reset.

- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- flush_valid  in  1  redirect request from the backend.
- flush_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- ic_req_valid  out  1  fetch request valid.
- ic_req_addr  out  XLEN  fetch address (= fetch_pc).
- ic_req_ready  in  1  I-cache accepts the request.
- ic_rsp_valid  in  1  fetch response valid; arrives ≥1 cycle after acceptance.
- ic_rsp_inst  in  32  fetched instruction.
- inst  out  32  head instruction; 0 when queue empty.
- pc  out  XLEN  head PC; 0 when empty.
- pnpc  out  XLEN  head predicted next PC; 0 when empty.
- out_valid  out  1  head valid toward decode.
- next_ready  in  1  decode can accept (decode's out_ready).
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: fetch_pc, outstanding flag, stale flag, req_pc, FIFO storage {inst, pc, pnpc} × DEPTH, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count.
- Issue: ic_req_valid = !outstanding && (count < DEPTH) && !flush_valid. This is combinational from state and flush_valid. On accept (ic_req_valid && ic_req_ready): outstanding←1, req_pc←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^XLEN).
- Slot reservation: requests issue only while count < DEPTH with nothing outstanding, so a response always has a free slot, even when a pop does not occur that cycle.
- Response: ic_rsp_valid is ignored unless outstanding=1. If stale=0, push {ic_rsp_inst, req_pc, req_pc+4} at wr_ptr. In both cases outstanding←0 and stale←0.
- Pop: when out_valid && next_ready, rd_ptr++.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- out_valid = (count≠0) && !flush_valid.
- Flush (priority over push, pop, and issue):
  - count←0, rd_ptr←wr_ptr←0, fetch_pc←{flush_pc[XLEN-1:2],2'b00}.
  - If outstanding stays set after this cycle, stale←1.
  - A response arriving in the flush cycle is dropped: outstanding←0, stale←0.
  - A request cannot be accepted in the flush cycle, because ic_req_valid is gated low.
- Back-to-back flushes: each reloads fetch_pc. The last one wins.

## Timing
- Reset (reset=0): fetch_pc=RESET_PC; outstanding=stale=0; count=0; pointers 0.
- Outputs during reset: ic_req_valid=0, out_valid=0, inst/pc/pnpc=0, ic_req_addr=RESET_PC.
- First cycle after reset release: ic_req_valid=1 with addr RESET_PC.
- Latency: a response in cycle N gives out_valid=1 in cycle N+1, holding that entry. There is no bypass.
- Throughput: at most one request per 2 cycles. The next request may issue in the cycle after the response.
- Reset asserted mid-operation: all state clears asynchronously. Any response still in flight after release is ignored, because outstanding=0.
- Head outputs are stable while out_valid=1 and next_ready=0.

## Test plan
- Reset, I-cache always ready, response 1 cycle after accept, next_ready=1:
  - requests go to 8000_0000, 8000_0004, 8000_0008 in cycles 1, 3, 5.
  - decode sees pc=8000_0000 / pnpc=8000_0004 with the matching inst, one cycle after each response.
- next_ready=0 with 6 fetches attempted:
  - exactly 4 requests issue, count=4, ic_req_valid stays 0.
  - raising next_ready drains the entries in order 8000_0000..8000_000C, and fetch resumes at 8000_0010.
- Flush with flush_pc=8000_0102 while a request is outstanding and count=2:
  - count→0, out_valid=0 in the flush cycle.
  - the late response is dropped.
  - the next request goes to 8000_0100.
  - the first entry popped has pc 8000_0100.
- Flush in the same cycle as a response and a pop:
  - nothing is pushed or popped, count=0.
  - next request addr = flush target.
- Push and pop in the same cycle at count=1: count stays 1 and ordering is preserved.
- Reset asserted while count=3 with an outstanding request:
  - outputs clear immediately, without waiting for a clock edge.
  - after release the first request is to RESET_PC.
  - a stray ic_rsp_valid is ignored.

Source files
------------

// File: rtl/ysyx_ifq.sv
// Fetch queue: one outstanding I-cache request, DEPTH-entry {inst, pc, pc+4} buffer; a response reaches decode next cycle.
// Backpressure: fetch stalls while a request is outstanding or the queue is full; a redirect empties the queue and drops the in-flight response.
module ysyx_ifq #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_valid,
  input  logic [XLEN-1:0]          flush_pc,
  output logic                     ic_req_valid,
  output logic [XLEN-1:0]          ic_req_addr,
  input  logic                     ic_req_ready,
  input  logic                     ic_rsp_valid,
  input  logic [31:0]              ic_rsp_inst,
  output logic [31:0]              inst,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          pnpc,
  output logic                     out_valid,
  input  logic                     next_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            stale;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;

  logic [31:0]     inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] pnpc_q [DEPTH];

  logic req_fire;
  logic rsp_fire;
  logic push;
  logic pop;
  logic head_vld;

  // Gating with reset keeps the request low while reset is held, not just after the first edge.
  assign ic_req_valid = reset && !outstanding && (count_q < CW'(DEPTH)) && !flush_valid;
  assign ic_req_addr  = fetch_pc;
  assign req_fire     = ic_req_valid && ic_req_ready;
  assign rsp_fire     = ic_rsp_valid && outstanding;
  assign push         = rsp_fire && !stale && !flush_valid;
  assign head_vld     = (count_q != '0);
  assign out_valid    = head_vld && !flush_valid;
  assign pop          = out_valid && next_ready;
  assign count        = count_q;

  assign inst = head_vld ? inst_q[rd_ptr] : '0;
  assign pc   = head_vld ? pc_q[rd_ptr]   : '0;
  assign pnpc = head_vld ? pnpc_q[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      stale       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
    end else if (flush_valid) begin
      fetch_pc <= {flush_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      // A fetch still in flight after the redirect must be discarded when it returns.
      if (outstanding && !ic_rsp_valid) begin
        stale <= 1'b1;
      end else begin
        outstanding <= 1'b0;
        stale       <= 1'b0;
      end
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (rsp_fire) begin
        outstanding <= 1'b0;
        stale       <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage needs no reset: head outputs are masked by the occupancy count.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_q[wr_ptr] <= ic_rsp_inst;
      pc_q[wr_ptr]   <= req_pc;
      pnpc_q[wr_ptr] <= req_pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_ysyx_ifq.sv
// Bench for ysyx_ifq: I-cache/decode stimulus with a queue-based reference model; a negedge monitor pops
// expected entries on every decode handshake.
module tb_ysyx_ifq;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush_valid = 1'b0;
  logic [XLEN-1:0]   flush_pc = '0;
  logic              ic_req_valid;
  logic [XLEN-1:0]   ic_req_addr;
  logic              ic_req_ready = 1'b0;
  logic              ic_rsp_valid = 1'b0;
  logic [31:0]       ic_rsp_inst = '0;
  logic [31:0]       inst;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pnpc;
  logic              out_valid;
  logic              next_ready = 1'b0;
  logic [2:0]        count;

  ysyx_ifq #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush_valid  (flush_valid),
    .flush_pc     (flush_pc),
    .ic_req_valid (ic_req_valid),
    .ic_req_addr  (ic_req_addr),
    .ic_req_ready (ic_req_ready),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_inst  (ic_rsp_inst),
    .inst         (inst),
    .pc           (pc),
    .pnpc         (pnpc),
    .out_valid    (out_valid),
    .next_ready   (next_ready),
    .count        (count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pnpc;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          ready_pct, nr_pct, flush_pct, stray_pct, dly_min, dly_max;
  logic        force_flush = 1'b0;
  logic [31:0] force_pc = '0;
  logic        pend_valid = 1'b0;
  logic        pend_stale = 1'b0;
  logic [31:0] pend_pc = '0;
  logic [31:0] model_pc = RESET_PC;
  int          pend_due = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          pops = 0;
  int          acc_cyc[8];
  logic [31:0] acc_addr[8];
  logic [31:0] first_pop_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic knobs(input int rdy, input int nr, input int fl, input int st, input int dmin, input int dmax);
    ready_pct = rdy; nr_pct = nr; flush_pct = fl; stray_pct = st; dly_min = dmin; dly_max = dmax;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on a negedge.
  task automatic apply_reset();
    reset = 1'b0;
    flush_valid = 1'b0; flush_pc = '0; ic_req_ready = 1'b0;
    ic_rsp_valid = 1'b0; ic_rsp_inst = '0; next_ready = 1'b0;
    #1;
    check("rst_req_valid", 64'(ic_req_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_head", 64'(inst | pc | pnpc), 64'(0));
    check("rst_addr", 64'(ic_req_addr), 64'(RESET_PC));
    exp_q.delete();
    pend_valid = 1'b0; pend_stale = 1'b0; pend_due = 0;
    model_pc = RESET_PC;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0; accepts = 0; pops = 0; first_pop_pc = '0;
  endtask

  // One clock cycle: drive after the edge, check and update the model before the next edge.
  task automatic step();
    logic rsp_now;
    logic stray;
    logic exp_rv;
    @(posedge clock);
    #1;
    cyc++;
    rsp_now = 1'b0;
    if (pend_valid) begin
      pend_due--;
      rsp_now = (pend_due == 0);
    end
    stray        = !pend_valid && ($urandom_range(99) < stray_pct);
    flush_valid  = force_flush || ($urandom_range(99) < flush_pct);
    flush_pc     = force_flush ? force_pc : 32'h8000_0000 + 32'($urandom_range(4095));
    ic_req_ready = ($urandom_range(99) < ready_pct);
    next_ready   = ($urandom_range(99) < nr_pct);
    ic_rsp_valid = rsp_now || stray;
    ic_rsp_inst  = $urandom;
    #1;
    check("count", 64'(count), 64'(exp_q.size()));
    exp_rv = !pend_valid && (exp_q.size() < DEPTH) && !flush_valid;
    check("req_valid", 64'(ic_req_valid), 64'(exp_rv));
    check("out_valid", 64'(out_valid), 64'((exp_q.size() != 0) && !flush_valid));
    if (exp_q.size() == 0) check("empty_head", 64'(inst | pc | pnpc), 64'(0));
    if (rsp_now) begin
      pend_valid = 1'b0;
      if (!pend_stale && !flush_valid) exp_q.push_back({ic_rsp_inst, pend_pc, pend_pc + 32'd4});
    end
    if (ic_req_valid === 1'b1 && ic_req_ready) begin
      check("req_addr", 64'(ic_req_addr), 64'(model_pc));
      if (accepts < 8) begin
        acc_cyc[accepts]  = cyc;
        acc_addr[accepts] = ic_req_addr;
      end
      accepts++;
      pend_valid = 1'b1;
      pend_stale = 1'b0;
      pend_pc    = model_pc;
      pend_due   = $urandom_range(dly_max, dly_min);
      model_pc   = model_pc + 32'd4;
    end
    if (flush_valid) begin
      exp_q.delete();
      model_pc = flush_pc & ~32'd3;
      if (pend_valid) pend_stale = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1 && next_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %0h with no entry expected at t=%0t", pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_inst", 64'(inst), 64'(mon_e.inst));
        check("pop_pc", 64'(pc), 64'(mon_e.pc));
        check("pop_pnpc", 64'(pnpc), 64'(mon_e.pnpc));
        if (pops == 0) first_pop_pc = pc;
        pops++;
      end
    end
  end

  initial begin
    knobs(0, 0, 0, 0, 1, 1);
    #3;
    apply_reset();

    // Free-running fetch: requests every other cycle.
    knobs(100, 100, 0, 0, 1, 1);
    repeat (8) step();
    check("s1_cyc0", 64'(acc_cyc[0]), 64'(1));
    check("s1_cyc1", 64'(acc_cyc[1]), 64'(3));
    check("s1_cyc2", 64'(acc_cyc[2]), 64'(5));
    check("s1_addr2", 64'(acc_addr[2]), 64'(32'h8000_0008));

    // Decode stalled: queue fills, then drains in order.
    apply_reset();
    knobs(100, 0, 0, 0, 1, 1);
    repeat (14) step();
    check("s2_accepts", 64'(accepts), 64'(4));
    check("s2_count", 64'(count), 64'(4));
    check("s2_req_valid", 64'(ic_req_valid), 64'(0));
    nr_pct = 100;
    repeat (12) step();
    check("s2_first_pop", 64'(first_pop_pc), 64'(32'h8000_0000));
    check("s2_resume_addr", 64'(acc_addr[4]), 64'(32'h8000_0010));

    // Redirect while a fetch is outstanding and two entries are queued.
    apply_reset();
    knobs(100, 0, 0, 0, 3, 3);
    for (int i = 0; i < 40 && !(exp_q.size() == 2 && pend_valid && pend_due >= 2); i++) step();
    check("s3_setup", 64'(exp_q.size() == 2 && pend_valid), 64'(1));
    force_flush = 1'b1; force_pc = 32'h8000_0102;
    step();
    force_flush = 1'b0;
    check("s3_flush_out_valid", 64'(out_valid), 64'(0));
    nr_pct = 100; pops = 0; first_pop_pc = '0;
    repeat (20) step();
    check("s3_first_pop", 64'(first_pop_pc), 64'(32'h8000_0100));

    // Redirect coinciding with a response and a ready decode.
    apply_reset();
    knobs(100, 0, 0, 0, 2, 2);
    for (int i = 0; i < 40 && !(exp_q.size() >= 1 && pend_valid && pend_due == 1); i++) step();
    check("s4_setup", 64'(exp_q.size() >= 1 && pend_valid), 64'(1));
    force_flush = 1'b1; force_pc = 32'h8000_0040; nr_pct = 100;
    step();
    force_flush = 1'b0;
    check("s4_flush_out_valid", 64'(out_valid), 64'(0));
    step();
    check("s4_count", 64'(count), 64'(0));
    check("s4_next_addr", 64'(ic_req_addr), 64'(32'h8000_0040));

    // Simultaneous push and pop with one entry queued.
    apply_reset();
    knobs(100, 0, 0, 0, 2, 2);
    for (int i = 0; i < 40 && !(exp_q.size() == 1 && pend_valid && pend_due == 1); i++) step();
    check("s5_setup", 64'(exp_q.size() == 1 && pend_valid), 64'(1));
    nr_pct = 100;
    step();
    nr_pct = 0;
    step();
    check("s5_count", 64'(count), 64'(1));

    // Randomized traffic with redirects and stray responses.
    apply_reset();
    knobs(70, 60, 5, 10, 1, 3);
    repeat (3000) step();

    // Reset mid-operation with three entries and an outstanding fetch.
    apply_reset();
    knobs(100, 0, 0, 0, 3, 3);
    for (int i = 0; i < 60 && !(exp_q.size() == 3 && pend_valid && pend_due >= 2); i++) step();
    @(posedge clock);
    #2;
    check("s7_pre_count", 64'(count), 64'(3));
    apply_reset();
    knobs(100, 100, 0, 100, 1, 1);
    step();
    stray_pct = 0;
    repeat (6) step();
    check("s7_first_addr", 64'(acc_addr[0]), 64'(RESET_PC));
    check("s7_first_cyc", 64'(acc_cyc[0]), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
